// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus master.
//   mem_size_t   : request access size encoding
//   lsu_state_t  : bus master FSM states
//   GPIO_BASE    : address of the GPIO output register used by benches
//   req_bad()    : alignment / size legality check applied at accept
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } lsu_state_t;

  localparam logic [31:0] GPIO_BASE = 32'hA000_0000;

  // True when the request must be rejected without touching the bus.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the bus master.
//   size        in  2   access size (mem_size_t encoding)
//   addr_lo     in  2   byte offset within the word
//   is_unsigned in  1   zero-extend loads when 1
//   rdata_word  in  32  word read from the bus
//   wdata       in  32  store data, right-justified
//   load_data   out 32  extracted and extended load result
//   merge_word  out 32  rdata_word with the store lane replaced
module lsu_align (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] rdata_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);
  import lsu_pkg::*;

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        byte_fill;
  logic        half_fill;

  // Load lane extraction with sign or zero extension.
  always_comb begin
    byte_val  = rdata_word[{addr_lo, 3'b000} +: 8];
    half_val  = rdata_word[{addr_lo[1], 4'b0000} +: 16];
    byte_fill = ~is_unsigned & byte_val[7];
    half_fill = ~is_unsigned & half_val[15];
    case (size)
      SZ_B:    load_data = {{24{byte_fill}}, byte_val};
      SZ_H:    load_data = {{16{half_fill}}, half_val};
      SZ_W:    load_data = rdata_word;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Store merge: the bus has no byte enables, so sub-word stores rewrite the whole word.
  always_comb begin
    merge_word = rdata_word;
    case (size)
      SZ_B:    merge_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SZ_H:    merge_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_W:    merge_word = wdata;
      default: merge_word = rdata_word;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// MEM-stage initiator for the single-cycle peripheral bus. Accepts one
// load/store at a time, issues word-aligned bus cycles, waits READ_LATENCY
// cycles for read data, returns extended load data and performs
// read-modify-write for byte/halfword stores. All outputs are registered.
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready high only in IDLE)
//   req_write/size/unsigned   request attributes
//   req_addr/req_wdata        byte address, right-justified store data
//   resp_valid/rdata/err      one-cycle response pulse, data, error flag
//   bus_address               word-aligned bus address
//   bus_write_data            full word to write
//   bus_write_enable          one-cycle write strobe
//   bus_read_enable           one-cycle read strobe
//   bus_read_data             read data, valid READ_LATENCY cycles after strobe
module lsu_bus_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic        bus_write_enable,
  output logic        bus_read_enable,
  input  logic [31:0] bus_read_data
);
  import lsu_pkg::*;

  lsu_state_t  state;
  lsu_state_t  state_next;
  logic [2:0]  wait_cnt;
  logic        wait_last;
  logic        accept;
  logic        accept_bad;
  logic        accept_wstore;
  logic        capture;
  logic [31:0] resp_rdata_next;

  // Request fields held for the whole operation.
  logic [1:0]  lat_size;
  logic [1:0]  lat_addr_lo;
  logic        lat_unsigned;
  logic        lat_write;
  logic [31:0] lat_wdata;

  logic [31:0] load_data;
  logic [31:0] merge_word;

  lsu_align u_align (
    .size        (lat_size),
    .addr_lo     (lat_addr_lo),
    .is_unsigned (lat_unsigned),
    .rdata_word  (bus_read_data),
    .wdata       (lat_wdata),
    .load_data   (load_data),
    .merge_word  (merge_word)
  );

  // Accept decode, read-data capture point and next state.
  always_comb begin
    accept          = req_valid & req_ready;
    accept_bad      = req_bad(req_size, req_addr[1:0]);
    accept_wstore   = req_write & (req_size == SZ_W);
    wait_last       = (wait_cnt == 3'(READ_LATENCY - 1));
    capture         = (state == RD_WAIT) & wait_last;
    resp_rdata_next = 32'h0000_0000;
    state_next      = state;
    case (state)
      IDLE: begin
        if (!accept) begin
          state_next = IDLE;
        end else if (accept_bad) begin
          state_next = ERR;
        end else if (accept_wstore) begin
          state_next = WR_ISSUE;
        end else begin
          state_next = RD_ISSUE;
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (!wait_last) begin
          state_next = RD_WAIT;
        end else if (lat_write) begin
          state_next = WR_ISSUE;
        end else begin
          state_next      = DONE;
          resp_rdata_next = load_data;
        end
      end
      WR_ISSUE: state_next = DONE;
      DONE:     state_next = IDLE;
      ERR:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State, latched request and registered outputs (derived from next state so
  // strobes and responses line up with the state they belong to).
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wait_cnt         <= 3'd0;
      lat_size         <= 2'b00;
      lat_addr_lo      <= 2'b00;
      lat_unsigned     <= 1'b0;
      lat_write        <= 1'b0;
      lat_wdata        <= 32'h0000_0000;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_err         <= 1'b0;
      resp_rdata       <= 32'h0000_0000;
      bus_address      <= 32'h0000_0000;
      bus_write_data   <= 32'h0000_0000;
      bus_write_enable <= 1'b0;
      bus_read_enable  <= 1'b0;
    end else begin
      state            <= state_next;
      wait_cnt         <= (state == RD_WAIT) ? wait_cnt + 3'd1 : 3'd0;
      req_ready        <= (state_next == IDLE);
      resp_valid       <= (state_next == DONE) | (state_next == ERR);
      resp_err         <= (state_next == ERR);
      resp_rdata       <= resp_rdata_next;
      bus_write_enable <= (state_next == WR_ISSUE);
      bus_read_enable  <= (state_next == RD_ISSUE);
      if (accept) begin
        lat_size     <= req_size;
        lat_addr_lo  <= req_addr[1:0];
        lat_unsigned <= req_unsigned;
        lat_write    <= req_write;
        lat_wdata    <= req_wdata;
      end
      // Address stays put from strobe through capture / write-back.
      if (accept && !accept_bad) begin
        bus_address <= {req_addr[31:2], 2'b00};
      end
      if (accept && !accept_bad && accept_wstore) begin
        bus_write_data <= req_wdata;
      end else if (capture && lat_write) begin
        bus_write_data <= merge_word;
      end
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench: RAM model plus GPIO register at GPIO_BASE behind two
// bus master instances (READ_LATENCY 1 and 3) sharing one memory.
module tb_lsu_bus_master;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  // READ_LATENCY = 1 instance
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata, bus_address, bus_write_data, bus_read_data;
  logic        bus_write_enable, bus_read_enable;
  // READ_LATENCY = 3 instance
  logic        q_req_valid, q_req_ready, q_req_write, q_req_unsigned;
  logic [1:0]  q_req_size;
  logic [31:0] q_req_addr, q_req_wdata;
  logic        q_resp_valid, q_resp_err;
  logic [31:0] q_resp_rdata, q_bus_address, q_bus_write_data, q_bus_read_data;
  logic        q_bus_write_enable, q_bus_read_enable;

  logic [31:0] mem [0:1023];
  logic [31:0] gpio_out;
  logic [31:0] pipe1;
  logic [31:0] q_p0, q_p1, q_p2;
  int          rd_cnt, wr_cnt, resp_cnt;
  int          total, bad;
  int          r0, w0, c0;

  lsu_bus_master #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_write_enable(bus_write_enable), .bus_read_enable(bus_read_enable),
    .bus_read_data(bus_read_data)
  );

  lsu_bus_master #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(q_req_valid), .req_ready(q_req_ready), .req_write(q_req_write),
    .req_size(q_req_size), .req_unsigned(q_req_unsigned), .req_addr(q_req_addr),
    .req_wdata(q_req_wdata), .resp_valid(q_resp_valid), .resp_rdata(q_resp_rdata),
    .resp_err(q_resp_err), .bus_address(q_bus_address), .bus_write_data(q_bus_write_data),
    .bus_write_enable(q_bus_write_enable), .bus_read_enable(q_bus_read_enable),
    .bus_read_data(q_bus_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return (a == GPIO_BASE) ? gpio_out : mem[a[11:2]];
  endfunction

  // Registered read responders: data appears only in its valid cycle, 0 otherwise.
  always @(posedge clk) begin
    pipe1 <= bus_read_enable ? bus_rd(bus_address) : 32'h0;
    q_p0  <= q_bus_read_enable ? bus_rd(q_bus_address) : 32'h0;
    q_p1  <= q_p0;
    q_p2  <= q_p1;
  end
  assign bus_read_data   = pipe1;
  assign q_bus_read_data = q_p2;

  // Write port shared by both instances.
  always @(posedge clk) begin
    if (bus_write_enable) begin
      if (bus_address == GPIO_BASE) gpio_out <= bus_write_data;
      else mem[bus_address[11:2]] <= bus_write_data;
    end else if (q_bus_write_enable) begin
      if (q_bus_address == GPIO_BASE) gpio_out <= q_bus_write_data;
      else mem[q_bus_address[11:2]] <= q_bus_write_data;
    end
  end

  // Strobe and response counters for the latency-1 instance.
  always @(posedge clk) begin
    if (bus_read_enable)  rd_cnt   <= rd_cnt + 1;
    if (bus_write_enable) wr_cnt   <= wr_cnt + 1;
    if (resp_valid)       resp_cnt <= resp_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns in cycle T+1 with fields scrambled.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    chk("ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_write = ~w; req_size = 2'b11; req_addr = 32'h0000_0FFF; req_wdata = 32'h0;
  endtask

  task automatic store_word(input logic [31:0] a, input logic [31:0] d);
    logic seen;
    seen = 1'b0;
    issue(1'b1, SZ_W, 1'b0, a, d);
    for (int i = 0; i < 20; i++) begin
      if (!seen) begin
        if (resp_valid) seen = 1'b1;
        else tick();
      end
    end
    chk("preload_resp", {31'd0, seen}, 32'd1);
    tick();
  endtask

  task automatic load_check(input string tag, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, sz, u, a, 32'h0);
    chk({tag, "_re"}, {31'd0, bus_read_enable}, 32'd1);
    chk({tag, "_addr"}, bus_address, {a[31:2], 2'b00});
    tick();
    chk({tag, "_early"}, {31'd0, resp_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_data"}, resp_rdata, exp);
    tick();
  endtask

  task automatic err_check(input string tag, input logic w, input logic [1:0] sz,
                           input logic [31:0] a);
    r0 = rd_cnt; w0 = wr_cnt;
    issue(w, sz, 1'b0, a, 32'h1234_5678);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, resp_err}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_strobe"}, {30'd0, bus_read_enable, bus_write_enable}, 32'd0);
    tick();
    chk({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_nobus"}, rd_cnt + wr_cnt, r0 + w0);
  endtask

  initial begin
    total = 0; bad = 0; rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    q_req_valid = 1'b0; q_req_write = 1'b0; q_req_size = 2'b00; q_req_unsigned = 1'b0;
    q_req_addr = 32'h0; q_req_wdata = 32'h0;
    tick(); tick();

    // Reset state
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    chk("rst_strobes", {30'd0, bus_read_enable, bus_write_enable}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_addr", bus_address, 32'h0);
    chk("rst_wdata", bus_write_data, 32'h0);
    rst = 1'b0;
    tick();

    // 1: word store to GPIO
    issue(1'b1, SZ_W, 1'b0, GPIO_BASE, 32'hDEAD_BEEF);
    chk("ws_we", {31'd0, bus_write_enable}, 32'd1);
    chk("ws_re", {31'd0, bus_read_enable}, 32'd0);
    chk("ws_addr", bus_address, 32'hA000_0000);
    chk("ws_data", bus_write_data, 32'hDEAD_BEEF);
    chk("ws_busy", {31'd0, req_ready}, 32'd0);
    tick();
    chk("ws_valid", {31'd0, resp_valid}, 32'd1);
    chk("ws_err", {31'd0, resp_err}, 32'd0);
    chk("ws_we_drop", {31'd0, bus_write_enable}, 32'd0);
    chk("ws_gpio", gpio_out, 32'hDEAD_BEEF);
    tick();
    chk("ws_ready_again", {31'd0, req_ready}, 32'd1);

    store_word(32'h0000_0100, 32'h80FF_7F01);
    store_word(32'h0000_0200, 32'h1122_3344);

    // 2: loads at T+3
    load_check("lb_101", SZ_B, 1'b0, 32'h0000_0101, 32'h0000_007F);
    load_check("lb_102", SZ_B, 1'b0, 32'h0000_0102, 32'hFFFF_FFFF);
    load_check("lhu_102", SZ_H, 1'b1, 32'h0000_0102, 32'h0000_80FF);
    load_check("lh_100", SZ_H, 1'b0, 32'h0000_0100, 32'h0000_7F01);
    load_check("lh_102", SZ_H, 1'b0, 32'h0000_0102, 32'hFFFF_80FF);

    // 3: byte store read-modify-write
    issue(1'b1, SZ_B, 1'b0, 32'h0000_0202, 32'h1234_56AA);
    chk("sb_re", {31'd0, bus_read_enable}, 32'd1);
    chk("sb_we_t1", {31'd0, bus_write_enable}, 32'd0);
    chk("sb_addr", bus_address, 32'h0000_0200);
    tick();
    chk("sb_t2", {30'd0, bus_read_enable, bus_write_enable}, 32'd0);
    tick();
    chk("sb_we", {31'd0, bus_write_enable}, 32'd1);
    chk("sb_merge", bus_write_data, 32'h11AA_3344);
    chk("sb_addr_hold", bus_address, 32'h0000_0200);
    chk("sb_no_resp", {31'd0, resp_valid}, 32'd0);
    tick();
    chk("sb_valid", {31'd0, resp_valid}, 32'd1);
    chk("sb_rdata", resp_rdata, 32'h0);
    chk("sb_mem", mem[10'h080], 32'h11AA_3344);
    tick();
    load_check("lbu_202", SZ_B, 1'b1, 32'h0000_0202, 32'h0000_00AA);
    load_check("lb_203", SZ_B, 1'b0, 32'h0000_0203, 32'h0000_0011);

    // 4: errors
    err_check("lw_103", 1'b0, SZ_W, 32'h0000_0103);
    err_check("sh_201", 1'b1, SZ_H, 32'h0000_0201);
    err_check("sz11_ld", 1'b0, SZ_BAD, 32'h0000_0200);
    err_check("sz11_st", 1'b1, SZ_BAD, 32'h0000_0200);

    // 5: reset during a halfword RMW
    issue(1'b1, SZ_H, 1'b0, 32'h0000_0200, 32'h0000_5555);
    chk("rmw_rst_re", {31'd0, bus_read_enable}, 32'd1);
    rst = 1'b1;
    w0 = wr_cnt; c0 = resp_cnt;
    tick();
    chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rmw_rst_strobes", {30'd0, bus_read_enable, bus_write_enable}, 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    chk("rmw_rst_nowrite", wr_cnt, w0);
    chk("rmw_rst_noresp", resp_cnt, c0);
    chk("rmw_rst_mem", mem[10'h080], 32'h11AA_3344);
    chk("rmw_rst_idle", {31'd0, req_ready}, 32'd1);

    // 6: back-to-back loads, READ_LATENCY = 3, req_valid held high
    chk("b2b_ready0", {31'd0, q_req_ready}, 32'd1);
    q_req_write = 1'b0; q_req_size = SZ_W; q_req_unsigned = 1'b0;
    q_req_addr = 32'h0000_0100; q_req_valid = 1'b1;
    tick();
    chk("b2b_re1", {31'd0, q_bus_read_enable}, 32'd1);
    chk("b2b_addr1", q_bus_address, 32'h0000_0100);
    chk("b2b_busy1", {31'd0, q_req_ready}, 32'd0);
    q_req_addr = 32'h0000_0200;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("b2b_wait1", {30'd0, q_resp_valid, q_req_ready}, 32'd0);
    end
    tick();
    chk("b2b_valid1", {31'd0, q_resp_valid}, 32'd1);
    chk("b2b_data1", q_resp_rdata, 32'h80FF_7F01);
    chk("b2b_busy_done", {31'd0, q_req_ready}, 32'd0);
    tick();
    chk("b2b_ready_t6", {31'd0, q_req_ready}, 32'd1);
    chk("b2b_no_re_t6", {31'd0, q_bus_read_enable}, 32'd0);
    tick();
    chk("b2b_re2", {31'd0, q_bus_read_enable}, 32'd1);
    chk("b2b_addr2", q_bus_address, 32'h0000_0200);
    q_req_valid = 1'b0;
    repeat (3) tick();
    chk("b2b_wait2", {31'd0, q_resp_valid}, 32'd0);
    tick();
    chk("b2b_valid2", {31'd0, q_resp_valid}, 32'd1);
    chk("b2b_data2", q_resp_rdata, 32'h11AA_3344);
    tick();
    chk("b2b_ready_end", {31'd0, q_req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
